// File: rtl/sim_run_ctrl.sv
// Run controller for a simulated CPU: holds it in reset, then watches it run until it halts or times out.
// Halt detection on the fetch PC is built only when SIM_RUN_CTRL_HALT_DETECT_EN is defined.
module sim_run_ctrl #(
   parameter int RESET_CYCLES = 5,
   parameter int MAX_CYCLES   = 50000,
   parameter int HALT_REPEAT  = 8,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             restart_i,
   input  logic [31:0]      pc_i,
   input  logic             pc_valid_i,
   output logic             cpu_reset_o,
   output logic             running_o,
   output logic             done_o,
   output logic             halted_o,
   output logic             timeout_o,
   output logic [CNT_W-1:0] cycle_cnt_o
);

   localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

   typedef enum logic [1:0] {RST_HOLD, RUN, HALTED, TIMEOUT} state_t;

   state_t            state, state_nxt;
   logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
   logic [CNT_W-1:0]  cyc_cnt, cyc_cnt_nxt;
   logic              halt_hit;
   logic              timeout_hit;

   assign timeout_hit = (cyc_cnt == CNT_W'(MAX_CYCLES - 1));

`ifdef SIM_RUN_CTRL_HALT_DETECT_EN
   localparam int REP_W = $clog2(HALT_REPEAT);

   logic [31:0]      pc_cap;
   logic             pc_cap_vld;
   logic [REP_W-1:0] rep_cnt;
   logic             pc_match;

   assign pc_match = pc_valid_i && pc_cap_vld && (pc_i == pc_cap);
   assign halt_hit = (state == RUN) && pc_match && (rep_cnt == REP_W'(HALT_REPEAT - 2));

   // Tracking is cleared outside RUN so every run captures its first valid PC fresh.
   always_ff @(posedge clk) begin
      if (reset || state != RUN) begin
         pc_cap_vld <= 1'b0;
         rep_cnt    <= '0;
      end else if (pc_valid_i) begin
         if (pc_match) begin
            rep_cnt <= rep_cnt + REP_W'(1);
         end else begin
            rep_cnt    <= '0;
            pc_cap     <= pc_i;
            pc_cap_vld <= 1'b1;
         end
      end
   end
`else
   logic unused_halt;

   assign halt_hit    = 1'b0;
   assign unused_halt = ^{pc_i, pc_valid_i, (HALT_REPEAT > 1)};
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= RST_HOLD;
         hold_cnt <= '0;
         cyc_cnt  <= '0;
      end else begin
         state    <= state_nxt;
         hold_cnt <= hold_cnt_nxt;
         cyc_cnt  <= cyc_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      hold_cnt_nxt = hold_cnt;
      cyc_cnt_nxt  = cyc_cnt;
      cpu_reset_o  = 1'b0;
      running_o    = 1'b0;
      done_o       = 1'b0;
      halted_o     = 1'b0;
      timeout_o    = 1'b0;
      case (state)
         RST_HOLD: begin
            cpu_reset_o = 1'b1;
            if (hold_cnt == HOLD_W'(RESET_CYCLES - 1)) begin
               state_nxt    = RUN;
               hold_cnt_nxt = '0;
            end else begin
               hold_cnt_nxt = hold_cnt + HOLD_W'(1);
            end
         end
         RUN: begin
            running_o   = 1'b1;
            cyc_cnt_nxt = cyc_cnt + CNT_W'(1);
            // A halt seen on the timeout edge wins.
            if (halt_hit) begin
               state_nxt = HALTED;
            end else if (timeout_hit) begin
               state_nxt = TIMEOUT;
            end
         end
         HALTED, TIMEOUT: begin
            done_o    = 1'b1;
            halted_o  = (state == HALTED);
            timeout_o = (state == TIMEOUT);
            if (restart_i) begin
               state_nxt    = RST_HOLD;
               hold_cnt_nxt = '0;
               cyc_cnt_nxt  = '0;
            end
         end
         default: begin
            state_nxt = RST_HOLD;
         end
      endcase
   end

   assign cycle_cnt_o = cyc_cnt;

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Bench for sim_run_ctrl: directed scenarios plus random PC streams against a run-outcome model.
// Two instances share stimulus: u0 (MAX_CYCLES=10, HALT_REPEAT=4) and u1 (MAX_CYCLES=6, HALT_REPEAT=6).
module tb_sim_run_ctrl;

   localparam int RC  = 5;
   localparam int MC0 = 10;
   localparam int HR0 = 4;
   localparam int MC1 = 6;
   localparam int HR1 = 6;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        restart = 1'b0;
   logic [31:0] pc = '0;
   logic        pc_valid = 1'b0;

   logic        cr0, rn0, dn0, hl0, to0;
   logic [31:0] cc0;
   logic        cr1, rn1, dn1, hl1, to1;
   logic [31:0] cc1;

   int total = 0;
   int bad   = 0;

   logic [31:0] pcq[$];
   bit          vq[$];
   bit          rq[$];

   typedef struct packed {
      logic        cr;
      logic        rn;
      logic        dn;
      logic        hl;
      logic        to;
      logic [31:0] cc;
   } obs_t;

   always #5 clk = ~clk;

   sim_run_ctrl #(.RESET_CYCLES(RC), .MAX_CYCLES(MC0), .HALT_REPEAT(HR0), .CNT_W(32)) u0 (
      .clk(clk), .reset(reset), .restart_i(restart), .pc_i(pc), .pc_valid_i(pc_valid),
      .cpu_reset_o(cr0), .running_o(rn0), .done_o(dn0), .halted_o(hl0), .timeout_o(to0),
      .cycle_cnt_o(cc0));

   sim_run_ctrl #(.RESET_CYCLES(RC), .MAX_CYCLES(MC1), .HALT_REPEAT(HR1), .CNT_W(32)) u1 (
      .clk(clk), .reset(reset), .restart_i(restart), .pc_i(pc), .pc_valid_i(pc_valid),
      .cpu_reset_o(cr1), .running_o(rn1), .done_o(dn1), .halted_o(hl1), .timeout_o(to1),
      .cycle_cnt_o(cc1));

   function automatic obs_t sample(input int sel);
      obs_t o;
      if (sel == 1) o = {cr1, rn1, dn1, hl1, to1, cc1};
      else          o = {cr0, rn0, dn0, hl0, to0, cc0};
      return o;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Run outcome from the rules: first HALT_REPEAT-long streak of equal valid PCs, else the cycle limit.
   function automatic void predict(input int maxc, input int hrep, output bit h, output int c);
      int endc;
      endc = maxc - 1;
      h    = 1'b0;
`ifdef SIM_RUN_CTRL_HALT_DETECT_EN
      begin
         int          streak;
         logic [31:0] last;
         bit          have;
         streak = 0;
         last   = '0;
         have   = 1'b0;
         for (int i = 0; i < maxc && i < pcq.size(); i++) begin
            if (vq[i]) begin
               if (have && pcq[i] == last) streak++;
               else begin
                  streak = 1;
                  last   = pcq[i];
                  have   = 1'b1;
               end
               if (streak >= hrep) begin
                  endc = i;
                  h    = 1'b1;
                  break;
               end
            end
         end
      end
`else
      if (hrep < 0) h = 1'b0;
`endif
      c = endc + 1;
   endfunction

   task automatic check_idle(input int sel, input string tag);
      obs_t o;
      o = sample(sel);
      chk({tag, "_cpu_reset"}, o.cr, 1);
      chk({tag, "_running"}, o.rn, 0);
      chk({tag, "_done"}, o.dn, 0);
      chk({tag, "_halted"}, o.hl, 0);
      chk({tag, "_timeout"}, o.to, 0);
      chk({tag, "_cnt"}, o.cc, 0);
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      reset    = 1'b1;
      restart  = 1'b0;
      pc_valid = 1'b0;
      repeat (n) @(negedge clk);
      check_idle(0, "reset");
      reset = 1'b0;
   endtask

   task automatic check_hold(input int sel, input string tag);
      int   n;
      obs_t o;
      n = 0;
      o = sample(sel);
      while (o.cr === 1'b1 && n < 40) begin
         n++;
         @(negedge clk);
         o = sample(sel);
      end
      chk({tag, "_len"}, n, RC);
      chk({tag, "_running"}, o.rn, 1);
      chk({tag, "_cnt0"}, o.cc, 0);
   endtask

   task automatic do_restart(input string tag);
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
      check_idle(0, tag);
      check_hold(0, tag);
   endtask

   task automatic run_check(input int sel, input int maxc, input int hrep, input string tag);
      bit   exp_h;
      int   exp_c;
      int   i;
      obs_t o;
      predict(maxc, hrep, exp_h, exp_c);
      i = 0;
      o = sample(sel);
      while (!o.dn && i < maxc + 3) begin
         chk({tag, "_runcnt"}, o.cc, i);
         pc       = (i < pcq.size()) ? pcq[i] : 32'h0;
         pc_valid = (i < vq.size()) ? vq[i] : 1'b0;
         restart  = (i < rq.size()) ? rq[i] : 1'b0;
         @(negedge clk);
         i++;
         o = sample(sel);
      end
      pc_valid = 1'b0;
      restart  = 1'b0;
      chk({tag, "_done"}, o.dn, 1);
      chk({tag, "_halted"}, o.hl, exp_h);
      chk({tag, "_timeout"}, o.to, !exp_h);
      chk({tag, "_cnt"}, o.cc, exp_c);
      chk({tag, "_running"}, o.rn, 0);
      chk({tag, "_cpu_reset"}, o.cr, 0);
      repeat (2) @(negedge clk);
      o = sample(sel);
      chk({tag, "_frozen"}, o.cc, exp_c);
   endtask

   task automatic load(input logic [31:0] p[], input bit v[]);
      pcq.delete();
      vq.delete();
      rq.delete();
      foreach (p[k]) begin
         pcq.push_back(p[k]);
         vq.push_back(v[k]);
      end
   endtask

   task automatic load_ramp(input logic [31:0] base, input int n);
      pcq.delete();
      vq.delete();
      rq.delete();
      for (int k = 0; k < n; k++) begin
         pcq.push_back(base + 32'(4 * k));
         vq.push_back(1'b1);
      end
   endtask

   initial begin
      int guard;

      // reset held 3 cycles, then the hold window
      do_reset(3);
      check_hold(0, "hold");

      // three distinct PCs then a 4-deep repeat
      load('{32'h3000, 32'h3004, 32'h3008, 32'h3008, 32'h3008, 32'h3008},
           '{1, 1, 1, 1, 1, 1});
      run_check(0, MC0, HR0, "halt");
`ifdef SIM_RUN_CTRL_HALT_DETECT_EN
      chk("halt_lit_cnt", cc0, 6);
      chk("halt_lit_flag", hl0, 1);
`endif

      // a stale capture of 0x3008 must not count toward the next run
      do_restart("rs1");
      load('{32'h3008, 32'h3008, 32'h3008, 32'h3010, 32'h3014, 32'h3018, 32'h301c,
             32'h3020, 32'h3024, 32'h3028, 32'h302c, 32'h3030},
           '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1});
      run_check(0, MC0, HR0, "fresh_cap");

      // invalid cycles in the middle of the repeat hold the streak
      do_restart("rs2");
      load('{32'h3000, 32'h3004, 32'h3008, 32'h3008, 32'h0, 32'h0, 32'h3008, 32'h3008},
           '{1, 1, 1, 1, 0, 0, 1, 1});
      run_check(0, MC0, HR0, "gap");
`ifdef SIM_RUN_CTRL_HALT_DETECT_EN
      chk("gap_lit_cnt", cc0, 8);
`endif

      // PC changing every cycle
      do_restart("rs3");
      load_ramp(32'h4000, 14);
      run_check(0, MC0, HR0, "timeout");
      chk("timeout_lit_cnt", cc0, MC0);

      // constant PC on u1: halt and timeout fall on the same edge
      do_reset(2);
      check_hold(1, "hold1");
      pcq.delete();
      vq.delete();
      rq.delete();
      for (int k = 0; k < 10; k++) begin
         pcq.push_back(32'h5000);
         vq.push_back(1'b1);
      end
      run_check(1, MC1, HR1, "coincide");
`ifdef SIM_RUN_CTRL_HALT_DETECT_EN
      chk("coincide_halted", hl1, 1);
      chk("coincide_timeout", to1, 0);
`endif

      // abort at cycle 7, rerun to timeout, then restart
      do_reset(1);
      check_hold(0, "hold2");
      guard = 0;
      while (cc0 !== 32'd7 && guard < 20) begin
         pc       = 32'h6000 + 32'(4 * guard);
         pc_valid = 1'b1;
         @(negedge clk);
         guard++;
      end
      chk("abort_reach", cc0, 7);
      reset = 1'b1;
      @(negedge clk);
      check_idle(0, "abort");
      reset    = 1'b0;
      pc_valid = 1'b0;
      check_hold(0, "abort_hold");
      load_ramp(32'h7000, 14);
      run_check(0, MC0, HR0, "abort_rerun");
      do_restart("rs4");

      // reset on the timeout edge wins
      guard = 0;
      while (cc0 !== 32'(MC0 - 1) && guard < 20) begin
         pc       = 32'h8000 + 32'(4 * guard);
         pc_valid = 1'b1;
         @(negedge clk);
         guard++;
      end
      chk("edge_reach", cc0, MC0 - 1);
      reset = 1'b1;
      @(negedge clk);
      check_idle(0, "reset_vs_timeout");
      reset    = 1'b0;
      pc_valid = 1'b0;
      check_hold(0, "hold3");
      load_ramp(32'h9000, 14);
      run_check(0, MC0, HR0, "pre_prio");

      // reset together with restart in a done state
      @(negedge clk);
      reset   = 1'b1;
      restart = 1'b1;
      @(negedge clk);
      reset   = 1'b0;
      restart = 1'b0;
      check_idle(0, "reset_vs_restart");
      check_hold(0, "hold4");
      load_ramp(32'ha000, 14);
      run_check(0, MC0, HR0, "post_prio");

      // random PC streams with stray restart pulses during RUN
      for (int it = 0; it < 12; it++) begin
         do_restart("rs_rand");
         pcq.delete();
         vq.delete();
         rq.delete();
         for (int k = 0; k < 14; k++) begin
            pcq.push_back(32'h100 + 32'(4 * $urandom_range(0, 2)));
            vq.push_back($urandom_range(0, 3) != 0);
            rq.push_back($urandom_range(0, 7) == 0);
         end
         run_check(0, MC0, HR0, "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sim_run_ctrl.md
SIM_RUN_CTRL -- requirements
Module: sim_run_ctrl

Interface
REQ-001 Parameters SHALL be, one per line:
- RESET_CYCLES, 5, cycles cpu_reset_o is held after reset deasserts (>=1).
- MAX_CYCLES, 50000, RUN cycles before timeout (>=1).
- HALT_REPEAT, 8, consecutive identical valid PCs declaring halt (>=2).
- CNT_W, 32, width of cycle_cnt_o; 2^CNT_W SHALL exceed MAX_CYCLES.
REQ-002 Ports SHALL be, one per line:
- clk, input, 1, single clock; all state updates on the rising edge.
- reset, input, 1, synchronous, active-high reset.
- restart_i, input, 1, one-cycle request to start a new run.
- pc_i, input, 32, DUT fetch PC.
- pc_valid_i, input, 1, pc_i is meaningful this cycle.
- cpu_reset_o, output, 1, reset driven into the DUT.
- running_o, output, 1, DUT is in its run window.
- done_o, output, 1, run finished (halt or timeout).
- halted_o, output, 1, run ended by halt detection.
- timeout_o, output, 1, run ended by cycle limit.
- cycle_cnt_o, output, CNT_W, RUN cycles elapsed.
REQ-003 There SHALL be one clock, clk; reset is synchronous and active-high, and no other asynchronous input exists.

Function
REQ-004 FSM states SHALL be RST_HOLD, RUN, HALTED, TIMEOUT; all outputs registered or decoded only from state.
REQ-005 RST_HOLD: cpu_reset_o=1, running_o=0; hold counter increments each cycle; at the edge where it equals RESET_CYCLES-1, state becomes RUN.
REQ-006 RUN: cpu_reset_o=0, running_o=1; cycle_cnt_o is 0 in the first RUN cycle and increments by 1 at every RUN edge.
REQ-007 Halt tracking in RUN: on a cycle with pc_valid_i=1, if pc_i equals the last captured PC then repeat count increments, else repeat count clears to 0 and pc_i is captured; with pc_valid_i=0 the count and captured PC hold.
REQ-008 Halt SHALL be detected at the edge where a valid pc_i matches and repeat count equals HALT_REPEAT-2 (i.e. HALT_REPEAT consecutive identical valid PCs); next state HALTED.
REQ-009 Timeout SHALL be detected at the RUN edge where cycle_cnt_o equals MAX_CYCLES-1; next state TIMEOUT, cycle_cnt_o becomes MAX_CYCLES.
REQ-010 Simultaneous halt and timeout SHALL resolve to HALTED (halted_o=1, timeout_o=0).
REQ-011 HALTED/TIMEOUT: done_o=1, running_o=0, cpu_reset_o=0, cycle_cnt_o frozen; exactly one of halted_o/timeout_o is 1.
REQ-012 restart_i in HALTED or TIMEOUT SHALL move to RST_HOLD next edge, clearing hold counter, cycle_cnt_o, repeat count, done_o, halted_o, timeout_o.
REQ-013 restart_i in RST_HOLD or RUN SHALL be ignored.
REQ-014 The first valid PC of a run SHALL always be captured (never compared against a stale PC from a previous run).

Reset
REQ-015 reset=1 at an edge SHALL force RST_HOLD with hold counter 0, cpu_reset_o=1, running_o=0, done_o=0, halted_o=0, timeout_o=0, cycle_cnt_o=0, repeat count 0, captured PC invalid.
REQ-016 reset asserted mid-run or in a done state SHALL abort immediately with the same values; cpu_reset_o then stays 1 for RESET_CYCLES cycles after reset falls.
REQ-017 reset SHALL take priority over restart_i, halt and timeout in the same cycle.

Configuration
REQ-018 Macro SIM_RUN_CTRL_HALT_DETECT_EN defined: halt tracking per REQ-007/008/010/014 present.
REQ-019 Macro undefined: halt logic SHALL be absent, halted_o tied 0, pc_i/pc_valid_i unused; a run ends only by timeout; all other behaviour unchanged.

Verification
REQ-020 Bench SHALL cover:
- Reset 3 cycles then release, RESET_CYCLES=5 -> cpu_reset_o high exactly 5 cycles after release, then running_o=1, cycle_cnt_o=0.
- Macro on, HALT_REPEAT=4, PC 0x3000,0x3004,0x3008 x4 -> HALTED after 4th 0x3008, done_o=1, halted_o=1, cycle_cnt_o=6.
- Same PC pattern with pc_valid_i low 2 cycles between repeats -> halt still after 4 valid repeats, cycle_cnt_o=8.
- MAX_CYCLES=10, PC changing each cycle -> timeout_o=1, done_o=1, cycle_cnt_o=10.
- MAX_CYCLES=6, HALT_REPEAT=6, constant PC from RUN start -> halt and timeout coincide, halted_o=1, timeout_o=0.
- Reset pulse at cycle_cnt_o=7, then restart_i in TIMEOUT -> both return to RST_HOLD, all flags 0, new run counts from 0.
